// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C bus-conditioning front end.
package i2c_pkg;

    // Width of the filter-length field (samples a new level must persist).
    localparam int LEN_W = 4;

    // Power-on configuration and SCL-low timeout defaults.
    localparam logic [LEN_W-1:0] I2C_DEF_LEN    = 4'd5;
    localparam int               I2C_DEF_PRESC  = 0;
    localparam int               I2C_TOUT_TICKS = 1000;

    // Bus-condition FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_APPLY = 2'd2
    } bus_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// One line conditioner: pin synchroniser plus a tick-gated stability filter.
module i2c_line_filter
    import i2c_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             pin,
    input  logic             tick,
    input  logic             clr,
    input  logic [LEN_W-1:0] len,
    output logic             line_f
);

    logic             sync_q1, sync_q2;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W:0]   cnt_inc;

    // One extra bit so the compare never wraps; len = 0 is always met, i.e. acts as len = 1.
    assign cnt_inc = {1'b0, cnt} + (LEN_W+1)'(1);

    // Two-flop synchroniser; resets high like an idle I2C line.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= pin;
            sync_q2 <= sync_q1;
        end
    end

    // A new level must differ from the output on len consecutive ticks; any agreeing tick restarts.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            line_f <= 1'b1;
        end else if (clr) begin
            cnt <= '0;
        end else if (tick) begin
            if (sync_q2 == line_f) begin
                cnt <= '0;
            end else if (cnt_inc >= {1'b0, len}) begin
                line_f <= sync_q2;
                cnt    <= '0;
            end else begin
                cnt <= cnt_inc[LEN_W-1:0];
            end
        end
    end

endmodule

// File: rtl/i2c_bus_cond_ctrl.sv
// I2C slave front end: filters SCL/SDA, decodes bus conditions, tracks busy and SCL-low timeout.
module i2c_bus_cond_ctrl
    import i2c_pkg::*;
#(
    parameter int                 PRESC_W    = 8,
    parameter logic [LEN_W-1:0]   DEF_LEN    = I2C_DEF_LEN,
    parameter logic [PRESC_W-1:0] DEF_PRESC  = PRESC_W'(I2C_DEF_PRESC),
    parameter int                 TOUT_W     = 16,
    parameter logic [TOUT_W-1:0]  TOUT_TICKS = TOUT_W'(I2C_TOUT_TICKS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               scl_in,
    input  logic               sda_in,
    input  logic               cfg_load,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [PRESC_W-1:0] cfg_prescale,
    output logic               cfg_pending,
    output logic               scl_f,
    output logic               sda_f,
    output logic               scl_rise,
    output logic               scl_fall,
    output logic               start_det,
    output logic               stop_det,
    output logic               bus_busy,
    output logic               timeout
);

    localparam int NUM_LINES = 2;

    bus_state_e           state, state_nx;
    logic                 load_active, load_shadow, apply;
    logic [LEN_W-1:0]     act_len, sh_len;
    logic [PRESC_W-1:0]   act_presc, sh_presc, presc_cnt;
    logic                 tick;
    logic [TOUT_W-1:0]    tout_cnt;
    logic [NUM_LINES-1:0] pin_v, line_v;
    logic                 scl_prev, sda_prev;

    // Line 0 is SCL, line 1 is SDA; both share the tick schedule and active length.
    assign pin_v = {sda_in, scl_in};

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        i2c_line_filter u_flt (
            .clk    (clk),
            .rst    (rst),
            .pin    (pin_v[i]),
            .tick   (tick),
            .clr    (apply),
            .len    (act_len),
            .line_f (line_v[i])
        );
    end

    assign scl_f = line_v[0];
    assign sda_f = line_v[1];

    // Sample-tick prescaler; restarts whenever a new configuration takes effect.
    assign tick = (presc_cnt == act_presc);

    always_ff @(posedge clk) begin
        if (rst)                        presc_cnt <= '0;
        else if (load_active || apply)  presc_cnt <= '0;
        else if (tick)                  presc_cnt <= '0;
        else                            presc_cnt <= presc_cnt + PRESC_W'(1);
    end

    // Previous filtered levels for edge and bus-condition decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_prev <= scl_f;
            sda_prev <= sda_f;
        end
    end

    // START/STOP need SCL stable high across the SDA edge, so a simultaneous SCL edge masks them.
    assign scl_rise  =  scl_f & ~scl_prev;
    assign scl_fall  = ~scl_f &  scl_prev;
    assign start_det =  scl_f &  scl_prev &  sda_prev & ~sda_f;
    assign stop_det  =  scl_f &  scl_prev & ~sda_prev &  sda_f;

    // SCL-low timeout: counts ticks of continuous SCL low while the bus is owned.
    assign timeout = (state == ST_BUSY) && (tout_cnt == TOUT_TICKS);

    always_ff @(posedge clk) begin
        if (rst)                                          tout_cnt <= '0;
        else if (state != ST_BUSY || timeout || scl_f)    tout_cnt <= '0;
        else if (tick)                                    tout_cnt <= tout_cnt + TOUT_W'(1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // Next state and config strobes; config loads go straight to active only when the bus is free.
    always_comb begin
        state_nx    = state;
        load_active = 1'b0;
        load_shadow = 1'b0;
        apply       = 1'b0;
        case (state)
            ST_IDLE: begin
                load_active = cfg_load;
                if (start_det) state_nx = ST_BUSY;
            end
            ST_BUSY: begin
                load_shadow = cfg_load;
                if (stop_det || timeout)
                    state_nx = (cfg_pending || cfg_load) ? ST_APPLY : ST_IDLE;
            end
            ST_APPLY: begin
                apply       = 1'b1;
                load_active = cfg_load;
                state_nx    = start_det ? ST_BUSY : ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign bus_busy = (state == ST_BUSY);

    // Active/shadow configuration; a direct load wins over the deferred copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_len     <= DEF_LEN;
            act_presc   <= DEF_PRESC;
            sh_len      <= '0;
            sh_presc    <= '0;
            cfg_pending <= 1'b0;
        end else begin
            if (load_active) begin
                act_len   <= cfg_len;
                act_presc <= cfg_prescale;
            end else if (apply) begin
                act_len   <= sh_len;
                act_presc <= sh_presc;
            end
            if (load_shadow) begin
                sh_len      <= cfg_len;
                sh_presc    <= cfg_prescale;
                cfg_pending <= 1'b1;
            end else if (apply) begin
                cfg_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_bus_cond_ctrl.sv
// Scenario bench for i2c_bus_cond_ctrl against a cycle-stepped behavioural model.
module tb_i2c_bus_cond_ctrl;

    localparam int TT = 20;

    logic       clk = 1'b0;
    logic       rst, scl_in, sda_in, cfg_load;
    logic [3:0] cfg_len;
    logic [7:0] cfg_prescale;
    logic       cfg_pending, scl_f, sda_f, scl_rise, scl_fall;
    logic       start_det, stop_det, bus_busy, timeout;

    int total = 0, bad = 0;
    int n_start = 0, n_stop = 0, n_fall = 0, n_tout = 0;

    always #5 clk = ~clk;

    i2c_bus_cond_ctrl #(.TOUT_TICKS(16'd20)) dut (
        .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in),
        .cfg_load(cfg_load), .cfg_len(cfg_len), .cfg_prescale(cfg_prescale),
        .cfg_pending(cfg_pending), .scl_f(scl_f), .sda_f(sda_f),
        .scl_rise(scl_rise), .scl_fall(scl_fall), .start_det(start_det),
        .stop_det(stop_det), .bus_busy(bus_busy), .timeout(timeout)
    );

    // Model: pin delay line {sda,scl}, filtered levels, run lengths of disagreeing ticks, bus mode.
    logic [1:0] m_dl0 = 2'b11, m_dl1 = 2'b11, m_f = 2'b11, m_prev = 2'b11;
    int   m_run[2] = '{0, 0};
    int   m_len = 5, m_presc = 0, m_pcnt = 0, m_sh_len = 0, m_sh_presc = 0;
    int   m_low = 0, m_mode = 0;   // mode: 0 free, 1 owned, 2 applying config
    logic m_pend = 1'b0;

    function automatic logic [8:0] dut_vec();
        return {scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy, timeout, cfg_pending};
    endfunction

    function automatic logic [8:0] mdl_vec();
        logic st, sp, bz, to;
        st = m_prev[0] & m_f[0] & m_prev[1] & ~m_f[1];
        sp = m_prev[0] & m_f[0] & ~m_prev[1] & m_f[1];
        bz = (m_mode == 1);
        to = (m_mode == 1) && (m_low == TT);
        return {m_f[0], m_f[1], m_f[0] & ~m_prev[0], ~m_f[0] & m_prev[0], st, sp, bz, to, m_pend};
    endfunction

    task automatic model_edge();
        logic st, sp, to, tk, ld, app, ld_act;
        int   om, eff;
        if (rst) begin
            m_dl0 = 2'b11; m_dl1 = 2'b11; m_f = 2'b11; m_prev = 2'b11;
            m_run[0] = 0; m_run[1] = 0; m_len = 5; m_presc = 0; m_pcnt = 0;
            m_sh_len = 0; m_sh_presc = 0; m_low = 0; m_mode = 0; m_pend = 1'b0;
            return;
        end
        st = m_prev[0] & m_f[0] & m_prev[1] & ~m_f[1];
        sp = m_prev[0] & m_f[0] & ~m_prev[1] & m_f[1];
        to = (m_mode == 1) && (m_low == TT);
        tk = (m_pcnt == m_presc);
        ld = cfg_load;
        om = m_mode;
        app = (om == 2);
        ld_act = ld && (om != 1);
        if (om == 1 && !to && !m_f[0]) begin
            if (tk) m_low++;
        end else m_low = 0;
        eff = (m_len == 0) ? 1 : m_len;
        for (int i = 0; i < 2; i++) begin
            m_prev[i] = m_f[i];
            if (app) m_run[i] = 0;
            else if (tk) begin
                if (m_dl1[i] == m_f[i]) m_run[i] = 0;
                else if (m_run[i] + 1 >= eff) begin m_f[i] = m_dl1[i]; m_run[i] = 0; end
                else m_run[i]++;
            end
        end
        m_pcnt = (ld_act || app || tk) ? 0 : m_pcnt + 1;
        if (om == 1 && ld) begin m_sh_len = cfg_len; m_sh_presc = cfg_prescale; end
        if (ld_act) begin m_len = cfg_len; m_presc = cfg_prescale; end
        else if (app) begin m_len = m_sh_len; m_presc = m_sh_presc; end
        case (om)
            0: if (st) m_mode = 1;
            1: if (sp || to) m_mode = (m_pend || ld) ? 2 : 0;
            default: m_mode = st ? 1 : 0;
        endcase
        if (om == 1 && ld) m_pend = 1'b1;
        else if (app) m_pend = 1'b0;
        m_dl1 = m_dl0;
        m_dl0 = {sda_in, scl_in};
    endtask

    // One clock: advance model with the inputs seen at the edge, then tally DUT pulses.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        n_start += int'(start_det);
        n_stop  += int'(stop_det);
        n_fall  += int'(scl_fall);
        n_tout  += int'(timeout);
    endtask

    // Row: {scl, sda, cycles, load, len, prescale, rst}; load/rst apply on the first cycle only.
    task automatic apply_row(input int r[7], input int k);
        scl_in   = (r[0] != 0);
        sda_in   = (r[1] != 0);
        cfg_load = (k == 0) && (r[3] != 0);
        rst      = (k == 0) && (r[6] != 0);
        if (k == 0 && r[3] != 0) begin
            cfg_len      = r[4][3:0];
            cfg_prescale = r[5][7:0];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; scl_in = 1'b1; sda_in = 1'b1; cfg_load = 1'b0; cfg_len = 4'd0; cfg_prescale = 8'd0;
        step(); step();
        total++;
        if (dut_vec() !== 9'b110000000) begin
            bad++; $display("FAIL reset_state: got %b want %b", dut_vec(), 9'b110000000);
        end
        rst = 1'b0;
        step();
        total++;
        if (dut_vec() !== mdl_vec()) begin
            bad++; $display("FAIL reset_idle: got %b want %b", dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_glitch();
        int t[4][7] = '{'{1,0,4,0,0,0,0}, '{1,1,12,0,0,0,0}, '{1,0,5,0,0,0,0}, '{1,1,20,0,0,0,0}};
        int since = 0, fall_at = -1;
        bit early = 0;
        for (int p = 0; p < 4; p++)
            for (int k = 0; k < t[p][2]; k++) begin
                apply_row(t[p], k); step(); total++;
                if (dut_vec() !== mdl_vec()) begin
                    bad++; $display("FAIL glitch r%0d c%0d: got %b want %b", p, k, dut_vec(), mdl_vec());
                end
                if (p < 2 && !sda_f) early = 1;
                if (p >= 2) begin since++; if (fall_at < 0 && !sda_f) fall_at = since; end
            end
        total++;
        if (early !== 1'b0) begin bad++; $display("FAIL glitch4_passed: got %0d want 0", early); end
        total++;
        if (fall_at != 7) begin bad++; $display("FAIL glitch5_latency: got %0d want 7", fall_at); end
    endtask

    task automatic test_prescale();
        int t[6][7] = '{'{1,1,2,1,2,3,0}, '{0,1,8,0,0,0,0}, '{1,1,16,0,0,0,0},
                        '{0,1,4,0,0,0,0}, '{1,1,16,0,0,0,0}, '{1,1,3,1,5,0,0}};
        int f0 = n_fall;
        for (int p = 0; p < 6; p++)
            for (int k = 0; k < t[p][2]; k++) begin
                apply_row(t[p], k); step(); total++;
                if (dut_vec() !== mdl_vec()) begin
                    bad++; $display("FAIL prescale r%0d c%0d: got %b want %b", p, k, dut_vec(), mdl_vec());
                end
                if ((p == 2 || p == 4) && k == t[p][2] - 1) begin
                    total++;
                    if (n_fall - f0 != 1) begin
                        bad++; $display("FAIL prescale_falls r%0d: got %0d want 1", p, n_fall - f0);
                    end
                end
            end
    endtask

    task automatic test_start_stop();
        int t[8][7] = '{'{1,0,10,0,0,0,0}, '{0,0,10,0,0,0,0}, '{0,1,10,0,0,0,0}, '{1,1,10,0,0,0,0},
                        '{1,0,10,0,0,0,0}, '{0,0,10,0,0,0,0}, '{1,0,10,0,0,0,0}, '{1,1,10,0,0,0,0}};
        int s0 = n_start, p0 = n_stop;
        for (int p = 0; p < 8; p++)
            for (int k = 0; k < t[p][2]; k++) begin
                apply_row(t[p], k); step(); total++;
                if (dut_vec() !== mdl_vec()) begin
                    bad++; $display("FAIL startstop r%0d c%0d: got %b want %b", p, k, dut_vec(), mdl_vec());
                end
                if ((p == 0 || p == 4) && k == 9) begin
                    total++;
                    if (bus_busy !== 1'b1) begin bad++; $display("FAIL busy_after_start r%0d: got %b want 1", p, bus_busy); end
                end
            end
        total++;
        if (n_start - s0 != 2 || n_stop - p0 != 1) begin
            bad++; $display("FAIL start_stop_count: got %0d/%0d want 2/1", n_start - s0, n_stop - p0);
        end
        total++;
        if (bus_busy !== 1'b0) begin bad++; $display("FAIL busy_after_stop: got %b want 0", bus_busy); end
    endtask

    task automatic test_cfg_pending();
        int t[10][7] = '{'{1,0,10,0,0,0,0}, '{0,0,10,1,3,0,0}, '{0,0,10,1,7,0,0}, '{1,0,10,0,0,0,0},
                         '{1,1,12,0,0,0,0}, '{1,0,6,0,0,0,0}, '{1,1,12,0,0,0,0}, '{1,0,7,0,0,0,0},
                         '{1,1,20,0,0,0,0}, '{1,1,3,1,5,0,0}};
        int s0 = 0;
        for (int p = 0; p < 10; p++)
            for (int k = 0; k < t[p][2]; k++) begin
                apply_row(t[p], k); step(); total++;
                if (dut_vec() !== mdl_vec()) begin
                    bad++; $display("FAIL cfgpend r%0d c%0d: got %b want %b", p, k, dut_vec(), mdl_vec());
                end
                if (p == 5 && k == 0) s0 = n_start;
                if (k == t[p][2] - 1) begin
                    if (p == 2) begin
                        total++;
                        if (cfg_pending !== 1'b1) begin bad++; $display("FAIL pending_set: got %b want 1", cfg_pending); end
                    end
                    if (p == 4) begin
                        total++;
                        if (cfg_pending !== 1'b0) begin bad++; $display("FAIL pending_clear: got %b want 0", cfg_pending); end
                    end
                    if (p == 6) begin
                        total++;
                        if (n_start - s0 != 0) begin bad++; $display("FAIL len7_blocks6: got %0d starts want 0", n_start - s0); end
                    end
                    if (p == 8) begin
                        total++;
                        if (n_start - s0 != 1) begin bad++; $display("FAIL len7_passes7: got %0d starts want 1", n_start - s0); end
                    end
                end
            end
    endtask

    task automatic test_timeout();
        int t[6][7] = '{'{1,0,10,0,0,0,0}, '{0,0,19,0,0,0,0}, '{1,0,10,0,0,0,0},
                        '{0,0,20,0,0,0,0}, '{1,0,10,0,0,0,0}, '{1,1,12,0,0,0,0}};
        int t0 = n_tout;
        for (int p = 0; p < 6; p++)
            for (int k = 0; k < t[p][2]; k++) begin
                apply_row(t[p], k); step(); total++;
                if (dut_vec() !== mdl_vec()) begin
                    bad++; $display("FAIL timeout r%0d c%0d: got %b want %b", p, k, dut_vec(), mdl_vec());
                end
                if (p == 2 && k == 9) begin
                    total++;
                    if (n_tout - t0 != 0 || bus_busy !== 1'b1) begin
                        bad++; $display("FAIL tout_19: got %0d pulses busy=%b want 0 busy=1", n_tout - t0, bus_busy);
                    end
                end
                if (p == 4 && k == 9) begin
                    total++;
                    if (n_tout - t0 != 1 || bus_busy !== 1'b0) begin
                        bad++; $display("FAIL tout_20: got %0d pulses busy=%b want 1 busy=0", n_tout - t0, bus_busy);
                    end
                end
            end
    endtask

    task automatic test_simul_reset();
        int t[8][7] = '{'{0,0,10,0,0,0,0}, '{1,1,10,0,0,0,0}, '{1,0,10,0,0,0,0}, '{0,0,5,1,9,0,0},
                        '{0,0,1,0,0,0,1}, '{1,1,12,0,0,0,0}, '{1,0,5,0,0,0,0}, '{1,1,12,0,0,0,0}};
        int s0 = n_start, p0 = n_stop, s1 = 0;
        for (int p = 0; p < 8; p++)
            for (int k = 0; k < t[p][2]; k++) begin
                apply_row(t[p], k); step(); total++;
                if (dut_vec() !== mdl_vec()) begin
                    bad++; $display("FAIL simulrst r%0d c%0d: got %b want %b", p, k, dut_vec(), mdl_vec());
                end
                if (p == 1 && k == 9) begin
                    total++;
                    if (n_start != s0 || n_stop != p0) begin
                        bad++; $display("FAIL same_cycle_toggle: got %0d/%0d want 0/0", n_start - s0, n_stop - p0);
                    end
                end
                if (p == 4) begin
                    total++;
                    if (dut_vec() !== 9'b110000000) begin
                        bad++; $display("FAIL mid_reset: got %b want %b", dut_vec(), 9'b110000000);
                    end
                end
                if (p == 6 && k == 0) s1 = n_start;
            end
        total++;
        if (n_start - s1 != 1) begin bad++; $display("FAIL len5_after_reset: got %0d starts want 1", n_start - s1); end
        rst = 1'b0;
    endtask

    task automatic test_random();
        int r[7];
        for (int p = 0; p < 500; p++) begin
            r[0] = int'($urandom % 2);
            r[1] = int'($urandom % 2);
            r[2] = int'($urandom_range(1, 16));
            r[3] = int'($urandom % 6 == 0);
            r[4] = int'($urandom_range(0, 6));
            r[5] = int'($urandom_range(0, 2));
            r[6] = int'($urandom % 64 == 0);
            for (int k = 0; k < r[2]; k++) begin
                apply_row(r, k); step(); total++;
                if (dut_vec() !== mdl_vec()) begin
                    bad++; $display("FAIL random r%0d c%0d: got %b want %b", p, k, dut_vec(), mdl_vec());
                end
            end
        end
        cfg_load = 1'b0;
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_prescale();
        test_start_stop();
        test_cfg_pending();
        test_timeout();
        test_simul_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
